// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: state encoding,
// instruction format/sub-op codes, default watchdog limit and helpers.
package seq_pkg;

    // Sequencer states, in the order a datapath instruction walks them.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_WAIT_MEM = 3'd2,
        S_DECODE   = 3'd3,
        S_ISSUE    = 3'd4,
        S_EXEC     = 3'd5,
        S_HALTED   = 3'd6,
        S_ERROR    = 3'd7
    } seq_state_e;

    localparam int INST_W  = 16;
    localparam int COUNT_W = 16;

    // Format field inst[1:0]: this code marks a local control op; anything
    // else goes to the datapath controller.
    localparam logic [1:0] FMT_CTRL = 2'b11;

    // Control sub-op field inst[4:2]; remaining codes are illegal.
    localparam logic [2:0] OP_HALT = 3'b000;
    localparam logic [2:0] OP_JUMP = 3'b001;
    localparam logic [2:0] OP_NOP  = 3'b010;

    // Jump target starts at this bit of the instruction word.
    localparam int JUMP_LSB = 5;

    // Default number of EXEC cycles allowed before giving up on done.
    localparam int TIMEOUT_DEFAULT = 16;

    // Increment that sticks at all-ones instead of rolling over.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (&v) ? v : v + COUNT_W'(1);
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// EXEC-phase watchdog: counts EXEC cycles since the last clear and flags
// the cycle that is the last one the datapath is allowed to take.
module seq_watchdog
    import seq_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // Counter only has to reach TIMEOUT-1, the index of the final cycle.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // High during the TIMEOUT-th EXEC cycle; done in that cycle still counts.
    assign expired = (cnt_q == LAST);

    // Next count: clear wins, then advance while enabled, holding at LAST.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state registers use <= so every flop samples pre-edge values, independent of block order.
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/inst_sequencer.sv
// Instruction sequencer: fetches 16-bit words from instruction memory,
// executes local control ops (HALT/JUMP/NOP) itself and hands everything
// else to the datapath controller with a run pulse, waiting for done under
// a watchdog.
module inst_sequencer
    import seq_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                imem_rd,
    output logic [PC_W-1:0]     imem_addr,
    input  logic [INST_W-1:0]   imem_data,
    output logic [INST_W-1:0]   d_inst,
    output logic                run,
    input  logic                done,
    output logic [PC_W-1:0]     pc,
    output logic [COUNT_W-1:0]  instr_count,
    output logic                busy,
    output logic                halted,
    output logic                error
);

    seq_state_e           state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [INST_W-1:0]    d_inst_q, d_inst_d;
    logic [COUNT_W-1:0]   count_q, count_d;

    // Registered outputs, each a decode of the state being entered.
    logic imem_rd_q;
    logic run_q;
    logic busy_q;
    logic halted_q;
    logic error_q;

    logic wd_clear;
    logic wd_enable;
    logic wd_expired;

    // Fields of the instruction held in d_inst.
    logic [1:0]      inst_fmt;
    logic [2:0]      inst_op;
    logic [PC_W-1:0] jump_target;

    assign inst_fmt    = d_inst_q[1:0];
    assign inst_op     = d_inst_q[4:2];
    assign jump_target = d_inst_q[JUMP_LSB +: PC_W];

    seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // Next-state, program-counter, instruction and counter updates.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        d_inst_d  = d_inst_q;
        count_d   = count_q;
        wd_clear  = 1'b0;
        wd_enable = 1'b0;

        case (state_q)
            // Start restarts from address 0 with a fresh count, whether
            // we came up from reset or stopped on a HALT.
            S_IDLE, S_HALTED: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    count_d = '0;
                end
            end

            // Read strobe is up for this single cycle.
            S_FETCH: begin
                state_d = S_WAIT_MEM;
            end

            // Memory answers one cycle after the strobe; capture it here and
            // hold it until the next capture.
            S_WAIT_MEM: begin
                d_inst_d = imem_data;
                state_d  = S_DECODE;
            end

            S_DECODE: begin
                if (inst_fmt != FMT_CTRL) begin
                    state_d = S_ISSUE;
                end else begin
                    case (inst_op)
                        OP_HALT: begin
                            state_d = S_HALTED;
                        end
                        OP_JUMP: begin
                            pc_d    = jump_target;
                            state_d = S_FETCH;
                        end
                        OP_NOP: begin
                            pc_d    = pc_q + PC_W'(1);
                            state_d = S_FETCH;
                        end
                        default: begin
                            state_d = S_ERROR;
                        end
                    endcase
                end
            end

            // Run pulse goes out; the watchdog starts from zero for EXEC.
            S_ISSUE: begin
                wd_clear = 1'b1;
                state_d  = S_EXEC;
            end

            // Done wins over the watchdog in the final allowed cycle.
            S_EXEC: begin
                wd_enable = 1'b1;
                if (done) begin
                    count_d = sat_inc(count_q);
                    pc_d    = pc_q + PC_W'(1);
                    state_d = S_FETCH;
                end else if (wd_expired) begin
                    state_d = S_ERROR;
                end
            end

            // Sticky until reset.
            S_ERROR: begin
                state_d = S_ERROR;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath registers and output flags; reset overrides all inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            d_inst_q  <= '0;
            count_q   <= '0;
            imem_rd_q <= 1'b0;
            run_q     <= 1'b0;
            busy_q    <= 1'b0;
            halted_q  <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            d_inst_q  <= d_inst_d;
            count_q   <= count_d;
            imem_rd_q <= (state_d == S_FETCH);
            run_q     <= (state_d == S_ISSUE);
            busy_q    <= (state_d inside {S_FETCH, S_WAIT_MEM, S_DECODE, S_ISSUE, S_EXEC});
            halted_q  <= (state_d == S_HALTED);
            error_q   <= (state_d == S_ERROR);
        end
    end

    assign imem_rd     = imem_rd_q;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign d_inst      = d_inst_q;
    assign instr_count = count_q;
    assign run         = run_q;
    assign busy        = busy_q;
    assign halted      = halted_q;
    assign error       = error_q;

endmodule
